// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder step per clock behind valid/ready handshakes.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-2:0]    sum_sh_q, sum_sh_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [CW-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic s_bit, c_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    c_next   = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = c_next;
        // Partial bits accumulate in sum_sh; the visible sum register updates only once complete.
        sum_sh_d = (W-1)'({s_bit, sum_sh_q} >> 1);
        if (cnt_q == CW'(W-1)) begin
          sum_d   = {s_bit, sum_sh_q};
          cout_d  = c_next;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ c_next;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (W=8); ovf checks run when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, cin, out_ready;
  logic         in_ready, out_valid, cout, busy;
  logic [W-1:0] a, b, sum;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_adder #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge in IDLE; returns 1 time unit after the accepting edge.
  task automatic launch(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy_run"}, busy, 1);
    chk({tag, "_in_ready_run"}, in_ready, 0);
  endtask

  // Bounded wait for out_valid; exp_n is the number of edges it should take.
  task automatic wait_done(input string tag, input int exp_n);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_n);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec,
                              input logic eo);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo !== 1'b0 && eo !== 1'b1) chk({tag, "_ovf_exp_known"}, eo, 0);
`endif
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    chk({tag, "_in_ready_after"}, in_ready, 1);
    chk({tag, "_out_valid_after"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif

    // 0x35 + 0x4A = 0x7F
    launch("t1", 8'h35, 8'h4A, 1'b0);
    wait_done("t1", W);
    check_result("t1", 8'h7F, 1'b0, 1'b0);
    release_result("t1");

    // 0xFF + 0x01 = 0x100
    launch("t2a", 8'hFF, 8'h01, 1'b0);
    wait_done("t2a", W);
    check_result("t2a", 8'h00, 1'b1, 1'b0);
    release_result("t2a");

    // 0 + 0 + cin
    launch("t2b", 8'h00, 8'h00, 1'b1);
    wait_done("t2b", W);
    check_result("t2b", 8'h01, 1'b0, 1'b0);
    release_result("t2b");

    // 127 + 1 overflows signed
    launch("t3a", 8'h7F, 8'h01, 1'b0);
    wait_done("t3a", W);
    check_result("t3a", 8'h80, 1'b0, 1'b1);
    release_result("t3a");

    // -1 + -1 = -2, no signed overflow
    launch("t3b", 8'hFF, 8'hFF, 1'b0);
    wait_done("t3b", W);
    check_result("t3b", 8'hFE, 1'b1, 1'b0);
    release_result("t3b");

    // Stall in DONE: 0x20 + 0x11 + 1 = 0x32
    out_ready = 1'b0;
    launch("t4", 8'h20, 8'h11, 1'b1);
    wait_done("t4", W);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_out_valid", out_valid, 1);
      chk("t4_hold_in_ready", in_ready, 0);
      check_result("t4_hold", 8'h32, 1'b0, 1'b0);
    end
    release_result("t4");

    // Inputs wiggled during RUN must be ignored: 0x12 + 0x34 + 1 = 0x47
    launch("t5", 8'h12, 8'h34, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    wait_done("t5", W - 4);
    check_result("t5", 8'h47, 1'b0, 1'b0);
    release_result("t5");

    // Reset in the third RUN cycle aborts the operation
    launch("t6", 8'hAA, 8'h55, 1'b0);
    tick(); tick();
    chk("t6_busy_pre_rst", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_sum", sum, 0);
    chk("t6_rst_cout", cout, 0);

    // -100 + -121 + 1 = -220: wraps to 0x24 with carry and signed overflow
    launch("t6n", 8'h9C, 8'h87, 1'b1);
    wait_done("t6n", W);
    check_result("t6n", 8'h24, 1'b1, 1'b1);
    release_result("t6n");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
